sfifo_reg_prog: RTL and testbench
=================================

Name: sfifo_reg_prog

Overview:
Parametrised synchronous FIFO with registered head output, for metadata and hop queues in the packet pipeline. It generalises the per-type registered-output FIFOs in several ways:
- arbitrary data WIDTH;
- synchronous flush;
- programmable almost-full / almost-empty thresholds;
- sticky overflow/underflow error flags with drop-on-error semantics.

The head entry is held in an output register, so dout is valid whenever empty=0.

Parameters:
WIDTH, 32, data width in bits
DEPTH_NBITS, 3, log2 of storage-array depth
DEPTH, 1<<DEPTH_NBITS, storage-array entries; total capacity CAP = DEPTH+1 (array plus output register)

Ports:
clk  in  1  clock
`RESET_SIG  in  1  reset; one clock, reset is synchronous and active-high (port named by the codebase RESET_SIG macro)
din  in  WIDTH  write data
wr  in  1  write request
rd  in  1  read/pop request; dout is consumed in the same cycle
flush  in  1  synchronous discard of all contents
err_clr  in  1  clears sticky error flags
afull_thr  in  DEPTH_NBITS+1  almost-full threshold
aempty_thr  in  DEPTH_NBITS+1  almost-empty threshold
dout  out  WIDTH  head entry, registered
empty  out  1  no valid head, registered
full  out  1  count==CAP, registered
afull  out  1  count>=afull_thr, registered
aempty  out  1  count<=aempty_thr, registered
count  out  DEPTH_NBITS+1  occupancy including output register, registered
ncount  out  DEPTH_NBITS+1  next-cycle occupancy, combinational
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset values: dout=0, empty=1, full=0, count=0, afull=0, aempty=1, overflow=0, underflow=0; array pointers=0. Array contents are not reset.
- Effective operations:
  - rd_e = rd & ~empty & ~flush.
  - wr_e = wr & (~full | rd_e) & ~flush. A write while full succeeds if a read occurs in the same cycle.
- ncount = flush ? 0 : count + wr_e - rd_e.
- empty, full, afull and aempty are all registered from ncount, so they update with count.
- Output register update, in priority order:
  - flush: dout holds its value; empty <= 1.
  - rd_e with array non-empty: dout <= array[rptr]; rptr increments.
  - (wr_e & empty) or (rd_e & array empty & wr_e): dout <= din; the write bypasses the array.
  - rd_e with no replacement: empty <= 1; dout holds (stale).
  - Otherwise a wr_e writes array[wptr]; wptr increments.
- Latency: write to an empty FIFO is visible on dout and empty=0 the next cycle. Read-to-next-head is 1 cycle.
- Simultaneous rd/wr at count==1: dout <= din, count stays 1, empty stays 0.
- Simultaneous rd/wr at count==CAP: both succeed; count stays CAP; no overflow.
- Pointers are DEPTH_NBITS wide and wrap naturally. Array occupancy is tracked internally: 0..DEPTH.
- Errors:
  - wr & full & ~rd_e & ~flush: data dropped; overflow <= 1.
  - rd & empty & ~flush: no state change; underflow <= 1.
  - Errors are sticky until err_clr. If err_clr and a new error occur in the same cycle, the flag is set (set wins).
- flush: count <= 0, pointers <= 0, empty <= 1, full <= 0, aempty <= 1, afull <= (afull_thr==0).
  - flush overrides rd/wr in the same cycle; the write is discarded; no error flags are raised.
  - Sticky flags are unaffected by flush.
- Thresholds are sampled every cycle; a threshold change takes effect on afull/aempty one cycle later.
  - afull_thr > CAP: afull never asserts.
  - aempty_thr >= CAP: aempty is always 1.
- Reset asserted mid-operation has the same effect as reset, and takes priority over flush and all other inputs.
- Simulation-only diagnostics print an error on overflow/underflow attempts, guarded by inactive reset.

Test Plan:
All scenarios use WIDTH=16, DEPTH_NBITS=3, so CAP=9.
1. Fill/drain: write 0x0001..0x0009 on consecutive cycles.
   - full=1 and count=9 after the 9th write.
   - 10th write 0x000A sets overflow=1; count stays 9.
   - Read 9 times: dout sequence 0x0001..0x0009; empty=1 after the last read.
2. Bypass: write 0xBEEF to the empty FIFO → next cycle dout=0xBEEF, empty=0, count=1.
   - Then rd+wr 0xCAFE in the same cycle → next cycle dout=0xCAFE, count=1.
3. Full plus concurrent rd/wr: at count=9, rd+wr 0x1234 → count stays 9, overflow stays 0.
   - 0x1234 emerges as the last of the 9 reads.
4. Flush: with 5 entries, assert flush with wr=1 → next cycle count=0, empty=1, overflow=0.
   - A subsequent write 0x00AA appears on dout 1 cycle later.
5. Thresholds: afull_thr=6, aempty_thr=2.
   - Write 6 entries → afull rises on the cycle count becomes 6.
   - Read 4 → aempty rises when count becomes 2.
   - Change afull_thr to 10 → afull=0 on the next cycle.
6. Underflow and reset: read while empty → underflow=1, count=0.
   - err_clr → underflow=0.
   - Fill 3 entries, then assert `RESET_SIG → next cycle all outputs at reset values, dout=0.

Source files
------------

// File: rtl/sfifo_reg_prog.sv
// sfifo_reg_prog: synchronous FIFO with a registered head entry, flush,
// programmable almost-full/almost-empty thresholds and sticky error flags.
// Total capacity is DEPTH array entries plus the output register.

`ifndef RESET_SIG
`define RESET_SIG reset
`endif

module sfifo_reg_prog #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEPTH_NBITS = 3,
    parameter int unsigned DEPTH       = 1 << DEPTH_NBITS
) (
    input  logic                   clk,
    input  logic                   `RESET_SIG,
    input  logic [WIDTH-1:0]       din,
    input  logic                   wr,
    input  logic                   rd,
    input  logic                   flush,
    input  logic                   err_clr,
    input  logic [DEPTH_NBITS:0]   afull_thr,
    input  logic [DEPTH_NBITS:0]   aempty_thr,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic                   full,
    output logic                   afull,
    output logic                   aempty,
    output logic [DEPTH_NBITS:0]   count,
    output logic [DEPTH_NBITS:0]   ncount,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int unsigned CW  = DEPTH_NBITS + 1;
    localparam int unsigned PW  = DEPTH_NBITS;
    localparam int unsigned CAP = DEPTH + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [WIDTH-1:0] dout_q, dout_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             afull_q, afull_d;
    logic             aempty_q, aempty_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    acnt_q, acnt_d;
    logic             mem_we;

    logic             rd_e;
    logic             wr_e;
    logic             arr_empty;
    logic [CW-1:0]    ncount_w;

    // Effective operations after flush and full/empty qualification
    assign rd_e      = rd & ~empty_q & ~flush;
    assign wr_e      = wr & (~full_q | rd_e) & ~flush;
    assign arr_empty = (acnt_q == '0);
    assign ncount_w  = flush ? '0 : (count_q + CW'(wr_e) - CW'(rd_e));

    // Next-state: head register, array pointers, status and sticky errors
    always_comb begin
        dout_d   = dout_q;
        empty_d  = empty_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        acnt_d   = acnt_q;
        mem_we   = 1'b0;

        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            acnt_d  = '0;
            empty_d = 1'b1;
        end else if (rd_e && !arr_empty) begin
            // Refill head from the array; a concurrent write lands in the array
            dout_d = mem[rptr_q];
            rptr_d = rptr_q + PW'(1);
            if (wr_e) begin
                mem_we = 1'b1;
                wptr_d = wptr_q + PW'(1);
            end else begin
                acnt_d = acnt_q - CW'(1);
            end
        end else if (wr_e && (empty_q || rd_e)) begin
            // Bypass: array is empty, write goes straight to the head
            dout_d  = din;
            empty_d = 1'b0;
        end else if (rd_e) begin
            empty_d = 1'b1;
        end else if (wr_e) begin
            mem_we = 1'b1;
            wptr_d = wptr_q + PW'(1);
            acnt_d = acnt_q + CW'(1);
        end

        count_d  = ncount_w;
        full_d   = (ncount_w == CW'(CAP));
        afull_d  = (ncount_w >= afull_thr);
        aempty_d = (ncount_w <= aempty_thr);
        ovf_d    = (ovf_q & ~err_clr) | (wr & full_q & ~rd_e & ~flush);
        udf_d    = (udf_q & ~err_clr) | (rd & empty_q & ~flush);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (`RESET_SIG) begin
            dout_q   <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            acnt_q   <= '0;
        end else begin
            dout_q   <= dout_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            acnt_q   <= acnt_d;
        end
    end

    // Storage array write port; contents are not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wptr_q] <= din;
        end
    end

`ifdef SFIFO_DIAG
    // Simulation diagnostics for dropped writes and empty reads
    always_ff @(posedge clk) begin
        if (!`RESET_SIG) begin
            if (wr && full_q && !rd_e && !flush) $error("sfifo_reg_prog: write while full dropped");
            if (rd && empty_q && !flush)         $error("sfifo_reg_prog: read while empty");
        end
    end
`endif

    assign dout      = dout_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign afull     = afull_q;
    assign aempty    = aempty_q;
    assign count     = count_q;
    assign ncount    = ncount_w;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: tb/tb_sfifo_reg_prog.sv
// Directed table-driven bench for sfifo_reg_prog (WIDTH=16, DEPTH_NBITS=3, CAP=9).

`ifndef RESET_SIG
`define RESET_SIG reset
`endif

module tb_sfifo_reg_prog;

    localparam int unsigned W   = 16;
    localparam int unsigned DNB = 3;
    localparam int unsigned CAP = 9;

    logic           clk = 1'b0;
    logic           rst_s;
    logic [W-1:0]   din;
    logic           wr, rd, flush, err_clr;
    logic [DNB:0]   afull_thr, aempty_thr;
    logic [W-1:0]   dout;
    logic           empty, full, afull, aempty, overflow, underflow;
    logic [DNB:0]   count, ncount;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sfifo_reg_prog #(.WIDTH(W), .DEPTH_NBITS(DNB)) dut (
        .clk        (clk),
        .`RESET_SIG (rst_s),
        .din        (din),
        .wr         (wr),
        .rd         (rd),
        .flush      (flush),
        .err_clr    (err_clr),
        .afull_thr  (afull_thr),
        .aempty_thr (aempty_thr),
        .dout       (dout),
        .empty      (empty),
        .full       (full),
        .afull      (afull),
        .aempty     (aempty),
        .count      (count),
        .ncount     (ncount),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    typedef struct {
        logic        w, r, f, c;
        logic [15:0] d;
        logic [15:0] e_dout;
        logic        e_empty;
        int          e_count;
        logic        e_ovf;
        logic        e_udf;
    } vec_t;

    vec_t vecs [100];
    int   nv = 0;

    task automatic chk(input string name, input int idx, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=0x%0h want=0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic addv(input logic w, input logic r, input logic f, input logic c,
                        input logic [15:0] d, input logic [15:0] ed, input logic ee,
                        input int ec, input logic eo, input logic eu);
        vecs[nv].w = w; vecs[nv].r = r; vecs[nv].f = f; vecs[nv].c = c;
        vecs[nv].d = d; vecs[nv].e_dout = ed; vecs[nv].e_empty = ee;
        vecs[nv].e_count = ec; vecs[nv].e_ovf = eo; vecs[nv].e_udf = eu;
        nv++;
    endtask

    // Drive one cycle of inputs and advance past the edge
    task automatic cyc(input logic w, input logic r, input logic f, input logic c, input logic [15:0] d);
        wr = w; rd = r; flush = f; err_clr = c; din = d;
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; flush = 1'b0; err_clr = 1'b0;
    endtask

    task automatic chk_all(input int idx, input int ed, input int ee, input int ec,
                           input int eo, input int eu, input int af_t, input int ae_t);
        chk("dout",      idx, int'(dout),      ed);
        chk("empty",     idx, int'(empty),     ee);
        chk("count",     idx, int'(count),     ec);
        chk("full",      idx, int'(full),      int'(ec == CAP));
        chk("afull",     idx, int'(afull),     int'(ec >= af_t));
        chk("aempty",    idx, int'(aempty),    int'(ec <= ae_t));
        chk("overflow",  idx, int'(overflow),  eo);
        chk("underflow", idx, int'(underflow), eu);
    endtask

    initial begin
        rst_s = 1'b1; din = '0; wr = 0; rd = 0; flush = 0; err_clr = 0;
        afull_thr = 4'd8; aempty_thr = 4'd1;

        // Fill/drain with overflow
        for (int k = 1; k <= 9; k++) addv(1,0,0,0, 16'(k), 16'h0001, 0, k, 0, 0);
        addv(1,0,0,0, 16'h000A, 16'h0001, 0, 9, 1, 0);
        for (int i = 1; i <= 8; i++) addv(0,1,0,0, 16'h0, 16'(i+1), 0, 9-i, 1, 0);
        addv(0,1,0,0, 16'h0, 16'h0009, 1, 0, 1, 0);
        addv(0,0,0,1, 16'h0, 16'h0009, 1, 0, 0, 0);
        // Bypass and rd+wr at count 1
        addv(1,0,0,0, 16'hBEEF, 16'hBEEF, 0, 1, 0, 0);
        addv(1,1,0,0, 16'hCAFE, 16'hCAFE, 0, 1, 0, 0);
        // Full with concurrent rd/wr
        for (int k = 1; k <= 8; k++) addv(1,0,0,0, 16'(16'h0100 + k), 16'hCAFE, 0, k+1, 0, 0);
        addv(1,1,0,0, 16'h1234, 16'h0101, 0, 9, 0, 0);
        for (int i = 1; i <= 7; i++) addv(0,1,0,0, 16'h0, 16'(16'h0101 + i), 0, 9-i, 0, 0);
        addv(0,1,0,0, 16'h0, 16'h1234, 0, 1, 0, 0);
        addv(0,1,0,0, 16'h0, 16'h1234, 1, 0, 0, 0);
        // Flush overrides write, then post-flush write
        for (int k = 1; k <= 5; k++) addv(1,0,0,0, 16'(16'h0010 + k), 16'h0011, 0, k, 0, 0);
        addv(1,0,1,0, 16'h0099, 16'h0011, 1, 0, 0, 0);
        addv(1,0,0,0, 16'h00AA, 16'h00AA, 0, 1, 0, 0);
        addv(0,1,0,0, 16'h0, 16'h00AA, 1, 0, 0, 0);
        // Underflow, err_clr, set-wins, flush suppresses errors
        addv(0,1,0,0, 16'h0, 16'h00AA, 1, 0, 0, 1);
        addv(0,0,0,1, 16'h0, 16'h00AA, 1, 0, 0, 0);
        addv(0,1,0,0, 16'h0, 16'h00AA, 1, 0, 0, 1);
        addv(0,1,0,1, 16'h0, 16'h00AA, 1, 0, 0, 1);
        addv(0,0,0,1, 16'h0, 16'h00AA, 1, 0, 0, 0);
        addv(0,1,1,0, 16'h0, 16'h00AA, 1, 0, 0, 0);

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_s = 1'b0;
        chk_all(-1, 0, 1, 0, 0, 0, 8, 1);

        // Table: check combinational ncount before the edge, registered outputs after
        for (int i = 0; i < nv; i++) begin
            wr = vecs[i].w; rd = vecs[i].r; flush = vecs[i].f; err_clr = vecs[i].c; din = vecs[i].d;
            #1;
            chk("ncount", i, int'(ncount), vecs[i].e_count);
            @(posedge clk);
            #1;
            chk_all(i, int'(vecs[i].e_dout), int'(vecs[i].e_empty), vecs[i].e_count,
                    int'(vecs[i].e_ovf), int'(vecs[i].e_udf), 8, 1);
        end
        wr = 0; rd = 0; flush = 0; err_clr = 0;

        // Thresholds: afull at 6, aempty at 2, threshold change one cycle later
        afull_thr = 4'd6; aempty_thr = 4'd2;
        cyc(0,0,0,0, 16'h0);
        for (int k = 1; k <= 6; k++) begin
            cyc(1,0,0,0, 16'(16'h0200 + k));
            chk("thr_afull", 100 + k, int'(afull), int'(k >= 6));
            chk("thr_count", 100 + k, int'(count), k);
        end
        afull_thr = 4'd10;
        cyc(0,0,0,0, 16'h0);
        chk("afull_thr_gt_cap", 110, int'(afull), 0);
        for (int i = 1; i <= 4; i++) begin
            cyc(0,1,0,0, 16'h0);
            chk("thr_aempty", 110 + i, int'(aempty), int'((6 - i) <= 2));
            chk("thr_dout",   110 + i, int'(dout), 16'h0201 + i);
        end
        aempty_thr = 4'd0;
        cyc(0,0,0,0, 16'h0);
        chk("aempty_thr_drop", 120, int'(aempty), 0);
        aempty_thr = 4'd15;
        cyc(0,0,0,0, 16'h0);
        chk("aempty_thr_ge_cap", 121, int'(aempty), 1);

        // Reset mid-operation takes priority over write
        cyc(0,0,1,0, 16'h0);
        afull_thr = 4'd8; aempty_thr = 4'd1;
        for (int k = 1; k <= 3; k++) cyc(1,0,0,0, 16'(16'h0300 + k));
        cyc(0,1,0,0, 16'h0);
        cyc(0,1,0,0, 16'h0);
        cyc(0,1,0,0, 16'h0);
        cyc(0,1,0,0, 16'h0);
        chk("pre_rst_udf", 130, int'(underflow), 1);
        for (int k = 1; k <= 3; k++) cyc(1,0,0,0, 16'(16'h0400 + k));
        chk("pre_rst_count", 131, int'(count), 3);
        rst_s = 1'b1;
        cyc(1,1,0,0, 16'h0555);
        rst_s = 1'b0;
        chk_all(132, 0, 1, 0, 0, 0, 8, 1);
        // FIFO works after reset: pointers restarted cleanly
        cyc(1,0,0,0, 16'h0777);
        cyc(1,0,0,0, 16'h0888);
        cyc(0,1,0,0, 16'h0);
        chk("post_rst_dout", 133, int'(dout), 16'h0888);
        chk("post_rst_count", 133, int'(count), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound
    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
